load_use_hazard_controller: RTL
===============================

Name: load_use_hazard_controller

Overview:
Parametrised hazard and stall controller for the in-order RV32I pipeline. It generalises single-cycle load-use detection in four ways: configurable load latency through an in-flight load tracker, N read ports with per-port use enables, x0 exclusion, and pipeline-wide handling of memory stalls and branch flushes. It sits beside the ID/EX boundary and drives the IF/ID/EX pipeline-register enables and flushes. It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_WIDTH, 5, register-index width
NUM_READ_PORTS, 2, number of ID source-register ports checked
LOAD_LATENCY, 1, cycles after a load issues into EX during which its rd is not yet forwardable (>=1)
CNT_WIDTH, 32, stall-counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  NUM_READ_PORTS*REG_ADDR_WIDTH  packed source registers; port k in bits [k*W +: W]
id_rs_used  in  NUM_READ_PORTS  bit k high if port k is actually read
id_mem_to_reg  in  1  ID instruction is a load
id_rd  in  REG_ADDR_WIDTH  ID destination register
ex_branch_taken  in  1  EX resolved a taken branch/jump
mem_stall  in  1  data memory not ready; freeze whole pipeline
cnt_clear  in  1  clear stall counter
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold ID/EX source (ID stage)
stall_ex  out  1  hold EX/MEM and later
bubble_ex  out  1  load NOP into ID/EX
flush_if_id  out  1  zero IF/ID
flush_id_ex  out  1  zero ID/EX
stall_cnt  out  CNT_WIDTH  load-use stall cycles counted

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. Reset clears all tracker entries and stall_cnt.
- Tracker: LOAD_LATENCY entries {valid, rd}, index 0 youngest.
- match(k) = id_rs_used[k] & rs_k != 0 & any valid entry with rd == rs_k.
- load_use = id_valid & OR over k of match(k). Combinational, same cycle.
- Output equations (combinational):
  - stall_if = stall_id = mem_stall | (load_use & ~ex_branch_taken)
  - stall_ex = mem_stall
  - bubble_ex = load_use & ~mem_stall & ~ex_branch_taken
  - flush_if_id = flush_id_ex = ex_branch_taken & ~mem_stall
- Priority: mem_stall > ex_branch_taken > load_use.
  - Branch during mem_stall: flush is deferred. EX is frozen, so ex_branch_taken persists and the flush fires on the first cycle with mem_stall low.
- Tracker update at each clk edge, not in reset:
  - mem_stall=1: hold all entries.
  - Otherwise shift entry[i+1] <= entry[i]; entry[LOAD_LATENCY-1] retires.
  - entry[0].valid <= id_valid & id_mem_to_reg & id_rd != 0 & ~load_use & ~ex_branch_taken.
  - entry[0].rd <= id_rd.
  - A stalled or flushed load therefore inserts a bubble, never a tracked entry.
- Latency: with LOAD_LATENCY=L, a consumer immediately behind a load stalls exactly L cycles, assuming no mem_stall.
- Loads to x0 are never tracked. Reads of x0 never match. A port with id_rs_used=0 never matches.
- Multiple ports matching, or matching different entries: still a single stall. The stall is released when no valid matching entry remains.
- stall_cnt:
  - Increments by 1 on cycles where bubble_ex=1.
  - Saturates at all-ones.
  - cnt_clear zeros it synchronously and wins over increment. rst also zeros it.
- Reset mid-stall: the tracker empties, so stall_id falls next cycle unless mem_stall is high.

Decomposition:
- Package hazard_pkg:
  - REG_ADDR_WIDTH default
  - X0 constant (0)
  - tracker entry typedef {valid, rd}
- One sub-module, load_tracker: the shift-register tracker plus the per-port comparator. Interface: push/valid/rd, hold, id_rs/id_rs_used in, per-port match out.
- The top level holds the priority logic and the counter.

Test Plan:
1. L=1: load x5 issues; next ID reads rs1=x5 used -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle, then 0; stall_cnt=1.
2. L=3: load x7, consumer rs2=x7 directly behind -> bubble_ex high 3 consecutive cycles. Same consumer with one independent instruction in between -> 2 cycles.
3. Load x0 followed by a read of x0; and load x9 followed by an instruction with rs1=x9 but id_rs_used[0]=0 -> no stall in either case.
4. Load-use hazard while ex_branch_taken=1 -> flush_if_id=flush_id_ex=1, bubble_ex=0, stall_id=0, stall_cnt unchanged.
5. mem_stall=1 for 4 cycles with a hazard pending and a branch taken -> stall_if/id/ex=1, flushes 0, tracker held. On release, the flush fires that cycle.
6. CNT_WIDTH=3: force 9 stall cycles -> stall_cnt saturates at 7. Assert cnt_clear together with a stall -> 0. rst mid-stall -> tracker empty, no stall on the next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and types for the load-use hazard controller
//
// Purpose: default register-index width, the x0 register index, and the
// tracker entry layout used when the register width is the RV32I default.
// Ports: none (package).
package hazard_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int X0 = 0;

  typedef struct packed {
    logic                          valid;
    logic [DEF_REG_ADDR_WIDTH-1:0] rd;
  } tracker_entry_t;

endpackage

// File: rtl/load_use_hazard_controller_if.sv
// rtl/load_use_hazard_controller_if.sv - pipeline-side signal bundle of the hazard controller
//
// Purpose: groups the ID/EX status inputs and the pipeline-control outputs.
// Ports (signals):
//   id_valid, id_rs, id_rs_used, id_mem_to_reg, id_rd  - ID stage status
//   ex_branch_taken, mem_stall, cnt_clear               - EX/MEM status, counter clear
//   stall_if, stall_id, stall_ex, bubble_ex,
//   flush_if_id, flush_id_ex, stall_cnt                 - pipeline control / counter
// Modports: master drives status and observes control; slave is the controller.
interface load_use_hazard_controller_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int CNT_WIDTH      = 32
);

  logic                                     id_valid;
  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] id_rs;
  logic [NUM_READ_PORTS-1:0]                id_rs_used;
  logic                                     id_mem_to_reg;
  logic [REG_ADDR_WIDTH-1:0]                id_rd;
  logic                                     ex_branch_taken;
  logic                                     mem_stall;
  logic                                     cnt_clear;

  logic                                     stall_if;
  logic                                     stall_id;
  logic                                     stall_ex;
  logic                                     bubble_ex;
  logic                                     flush_if_id;
  logic                                     flush_id_ex;
  logic [CNT_WIDTH-1:0]                     stall_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_mem_to_reg, id_rd,
           ex_branch_taken, mem_stall, cnt_clear,
    input  stall_if, stall_id, stall_ex, bubble_ex,
           flush_if_id, flush_id_ex, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_mem_to_reg, id_rd,
           ex_branch_taken, mem_stall, cnt_clear,
    output stall_if, stall_id, stall_ex, bubble_ex,
           flush_if_id, flush_id_ex, stall_cnt
  );

endinterface

// File: rtl/load_tracker.sv
// rtl/load_tracker.sv - in-flight load tracker with per-port source comparators
//
// Purpose: remembers the rd of loads that are not yet forwardable, one entry
// per cycle of load latency (entry 0 youngest), and flags each ID read port
// whose source register matches a live entry.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (empties the tracker)
//   push        - a load leaves ID into EX this cycle and must be tracked
//   push_rd     - destination of that load
//   hold        - freeze all entries (memory stall)
//   id_rs       - packed ID source registers, port k in [k*W +: W]
//   id_rs_used  - per-port read enable
//   port_match  - per-port hazard flag
module load_tracker import hazard_pkg::*; #(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int NUM_READ_PORTS = 2,
  parameter int LOAD_LATENCY   = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     push,
  input  logic [REG_ADDR_WIDTH-1:0]                push_rd,
  input  logic                                     hold,
  input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [NUM_READ_PORTS-1:0]                id_rs_used,
  output logic [NUM_READ_PORTS-1:0]                port_match
);

  localparam logic [REG_ADDR_WIDTH-1:0] REG_X0 = REG_ADDR_WIDTH'(X0);

  logic [LOAD_LATENCY-1:0]                     valid_q;
  logic [LOAD_LATENCY-1:0][REG_ADDR_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rd_q    <= '0;
    end else if (!hold) begin
      // Oldest entry falls off the end: its result is forwardable from now on.
      for (int i = LOAD_LATENCY - 1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
        rd_q[i]    <= rd_q[i-1];
      end
      valid_q[0] <= push;
      rd_q[0]    <= push_rd;
    end
  end

  always_comb begin
    port_match = '0;
    for (int k = 0; k < NUM_READ_PORTS; k++) begin
      // Unused ports and x0 reads can never depend on a load.
      if (id_rs_used[k] && (id_rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != REG_X0)) begin
        for (int i = 0; i < LOAD_LATENCY; i++) begin
          if (valid_q[i] && (rd_q[i] == id_rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
            port_match[k] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/load_use_hazard_controller.sv
// rtl/load_use_hazard_controller.sv - load-use hazard, stall and flush controller
//
// Purpose: drives IF/ID/EX pipeline-register enables and flushes from the
// load tracker, memory stall and branch resolution, and counts load-use
// bubble cycles in a saturating counter.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (empties tracker, zeros counter)
//   bus  - slave modport of load_use_hazard_controller_if (status in, control out)
module load_use_hazard_controller import hazard_pkg::*; #(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int NUM_READ_PORTS = 2,
  parameter int LOAD_LATENCY   = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  load_use_hazard_controller_if.slave   bus
);

  localparam logic [REG_ADDR_WIDTH-1:0] REG_X0 = REG_ADDR_WIDTH'(X0);

  logic [NUM_READ_PORTS-1:0] port_match;
  logic                      load_use;
  logic                      push;
  logic                      stall_front;
  logic                      bubble;
  logic                      flush;
  logic [CNT_WIDTH-1:0]      cnt_q;

  assign load_use = bus.id_valid & (|port_match);

  // A load that is stalled or squashed leaves a bubble in EX, not a tracked entry.
  assign push = bus.id_valid & bus.id_mem_to_reg & (bus.id_rd != REG_X0)
              & ~load_use & ~bus.ex_branch_taken;

  load_tracker #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_READ_PORTS (NUM_READ_PORTS),
    .LOAD_LATENCY   (LOAD_LATENCY)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rd    (bus.id_rd),
    .hold       (bus.mem_stall),
    .id_rs      (bus.id_rs),
    .id_rs_used (bus.id_rs_used),
    .port_match (port_match)
  );

  // mem_stall freezes everything; a taken branch squashes the stalled consumer;
  // a branch seen during mem_stall persists in frozen EX, so its flush just waits.
  always_comb begin
    stall_front = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    if (bus.mem_stall) begin
      stall_front = 1'b1;
    end else if (bus.ex_branch_taken) begin
      flush = 1'b1;
    end else if (load_use) begin
      stall_front = 1'b1;
      bubble      = 1'b1;
    end
  end

  assign bus.stall_if    = stall_front;
  assign bus.stall_id    = stall_front;
  assign bus.stall_ex    = bus.mem_stall;
  assign bus.bubble_ex   = bubble;
  assign bus.flush_if_id = flush;
  assign bus.flush_id_ex = flush;
  assign bus.stall_cnt   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clear) begin
      cnt_q <= '0;
    end else if (bubble && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
